imem_loader: RTL

- Boot-time writer for the instruction memory that the core reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive instruction-memory word addresses.
- Holds the core in reset until the load completes, then releases it.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle of the boot-time loader.
// The slave side is the loader; the master side feeds bytes and observes writes.
interface imem_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;

    modport master (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a byte stream into little-endian words and holds
// the core in reset until the load completes. Optional checksum byte check: LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    imem_loader_if.slave          bus,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHK     = 3'd4;
`endif

    localparam logic [ADDR_WIDTH:0] ZERO_LEN  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] ONE_LEN   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]          state_r, state_s;
    logic [ADDR_WIDTH:0] len_r, len_s;
    logic [ADDR_WIDTH:0] word_idx_r, word_idx_s;
    logic [1:0]          byte_idx_r, byte_idx_s;
    logic [31:0]         asm_r, asm_s;
    logic                s_ready_r, s_ready_s;
    logic                imem_we_r, imem_we_s;
    logic [31:0]         imem_addr_r, imem_addr_s;
    logic [31:0]         imem_wd_r, imem_wd_s;
    logic                core_rst_n_r, core_rst_n_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic                accept_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          sum_r, sum_s;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    function automatic logic [31:0] word_addr(input logic [ADDR_WIDTH:0] idx);
        return BASE_ADDR + {{(32-ADDR_WIDTH-3){1'b0}}, idx, 2'b00};
    endfunction

    assign bus.s_ready   = s_ready_r;
    assign bus.imem_we   = imem_we_r;
    assign bus.imem_addr = imem_addr_r;
    assign bus.imem_wd   = imem_wd_r;
    assign core_rst_n    = core_rst_n_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

    // Next-state and next-output logic; outputs are decoded for the state being entered
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        word_idx_s   = word_idx_r;
        byte_idx_s   = byte_idx_r;
        asm_s        = asm_r;
        s_ready_s    = 1'b0;
        imem_we_s    = 1'b0;
        imem_addr_s  = imem_addr_r;
        imem_wd_s    = imem_wd_r;
        core_rst_n_s = core_rst_n_r;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        accept_s     = bus.s_valid && s_ready_r;
`ifdef LOADER_CHECKSUM_EN
        sum_s        = sum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_words == ZERO_LEN) begin
                        state_s      = ST_DONE;
                        done_s       = 1'b1;
                        core_rst_n_s = 1'b1;
                    end else if (len_words > MAX_WORDS) begin
                        err_s = 1'b1;
                    end else begin
                        state_s      = ST_COLLECT;
                        len_s        = len_words;
                        word_idx_s   = ZERO_LEN;
                        byte_idx_s   = 2'd0;
                        core_rst_n_s = 1'b0;
                        s_ready_s    = 1'b1;
                        busy_s       = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_s        = 8'd0;
`endif
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                busy_s = 1'b1;
                if (accept_s) begin
                    asm_s[{byte_idx_r, 3'b000} +: 8] = bus.s_data;
                    byte_idx_s = byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_s = csum_add(sum_r, bus.s_data);
`endif
                    if (byte_idx_r == 2'd3) begin
                        state_s     = ST_WRITE;
                        imem_we_s   = 1'b1;
                        imem_addr_s = word_addr(word_idx_r);
                        imem_wd_s   = asm_s;
                    end else begin
                        s_ready_s = 1'b1;
                    end
                end else begin
                    s_ready_s = 1'b1;
                end
            end
            ST_WRITE: begin
                word_idx_s = word_idx_r + ONE_LEN;
                if (word_idx_r == (len_r - ONE_LEN)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_s   = ST_CHK;
                    s_ready_s = 1'b1;
                    busy_s    = 1'b1;
`else
                    state_s      = ST_DONE;
                    done_s       = 1'b1;
                    core_rst_n_s = 1'b1;
`endif
                end else begin
                    state_s   = ST_COLLECT;
                    s_ready_s = 1'b1;
                    busy_s    = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    // The checksum byte brings the byte sum of the whole image to zero mod 256
                    if (csum_add(sum_r, bus.s_data) == 8'd0) begin
                        state_s      = ST_DONE;
                        done_s       = 1'b1;
                        core_rst_n_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end
                end else begin
                    s_ready_s = 1'b1;
                    busy_s    = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, assembly register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            len_r        <= ZERO_LEN;
            word_idx_r   <= ZERO_LEN;
            byte_idx_r   <= 2'd0;
            asm_r        <= 32'h0000_0000;
            s_ready_r    <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'h0000_0000;
            imem_wd_r    <= 32'h0000_0000;
            core_rst_n_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_r        <= 8'd0;
`endif
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            word_idx_r   <= word_idx_s;
            byte_idx_r   <= byte_idx_s;
            asm_r        <= asm_s;
            s_ready_r    <= s_ready_s;
            imem_we_r    <= imem_we_s;
            imem_addr_r  <= imem_addr_s;
            imem_wd_r    <= imem_wd_s;
            core_rst_n_r <= core_rst_n_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
`ifdef LOADER_CHECKSUM_EN
            sum_r        <= sum_s;
`endif
        end
    end

endmodule
